// File: rtl/uart_rx_ctrl.sv
// UART receive controller: samples a serial line and drives op/din of an external 9-bit SIPO.
// Build option RX_PARITY_EN: receive 8E1 (nine shifts plus an even-parity check) instead of 8N1.
module uart_rx_ctrl #(
  parameter int ClksPerBit = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [1:0] op_o,
  output logic       sdin_o,
  output logic       done_o,
  output logic       busy_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic [2:0] state_o
);

  localparam logic [1:0]  OP_CLEAR  = 2'b00;
  localparam logic [1:0]  OP_HOLD   = 2'b01;
  localparam logic [1:0]  OP_SHIFT  = 2'b10;
  localparam logic [15:0] HALF_LAST = 16'(ClksPerBit / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(ClksPerBit - 1);
`ifdef RX_PARITY_EN
  localparam logic [3:0]  NBITS     = 4'd9;
`else
  localparam logic [3:0]  NBITS     = 4'd8;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        armed_q, armed_d;
  logic        frame_err_q;
  logic        rx_meta, rx_s;
  logic        clear, sample;

  // Synchronizer resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      clk_cnt_q   <= 16'd0;
      bit_cnt_q   <= 4'd0;
      armed_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      armed_q   <= armed_d;
      if (clear) begin
        frame_err_q <= 1'b0;
      end else if (sample) begin
        frame_err_q <= ~rx_s;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    armed_d   = 1'b0;
    op_o      = OP_HOLD;
    sample    = 1'b0;
    case (state_q)
      IDLE: begin
        // A start needs a high-to-low transition, so a stuck-low line cannot retrigger.
        armed_d   = armed_q | rx_s;
        clk_cnt_d = 16'd0;
        if (armed_q && !rx_s) begin
          state_d = START;
          armed_d = 1'b0;
        end
      end
      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = 16'd0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_cnt_d = 4'd0;
            op_o      = OP_CLEAR;
          end else begin
            state_d = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = 16'd0;
          op_o      = OP_SHIFT;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == NBITS - 4'd1) begin
            state_d = STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = 16'd0;
          sample    = 1'b1;
          state_d   = DONE;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign clear = (op_o == OP_CLEAR);

`ifdef RX_PARITY_EN
  logic par_acc_q, parity_err_q;

  // Even parity: XOR over all nine shifted bits must be zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      par_acc_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      if (clear) begin
        par_acc_q <= 1'b0;
      end else if (op_o == OP_SHIFT) begin
        par_acc_q <= par_acc_q ^ rx_s;
      end
      if (clear) begin
        parity_err_q <= 1'b0;
      end else if (sample) begin
        parity_err_q <= par_acc_q;
      end
    end
  end

  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign sdin_o      = rx_s;
  assign done_o      = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign frame_err_o = frame_err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 16 clocks per bit, with a behavioural 9-bit SIPO.
module tb_uart_rx_ctrl;

  localparam int CPB = 16;
`ifdef RX_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [1:0] op;
  logic       sdin, done, busy, frame_err, parity_err;
  logic [2:0] state;

  logic [8:0]  sipo = 9'd0;
  logic [10:0] exp_q[$];

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int n_clear = 0, n_shift = 0, n_done = 0;
  int clear_cyc = 0, done_cyc = 0, last_evt = 0, start_cyc = 0;
  int d0, s0, c0;
  logic in_frame = 1'b0, prev_done = 1'b0;

  uart_rx_ctrl #(.ClksPerBit(CPB)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rx_i         (rx),
    .op_o         (op),
    .sdin_o       (sdin),
    .done_o       (done),
    .busy_o       (busy),
    .frame_err_o  (frame_err),
    .parity_err_o (parity_err),
    .state_o      (state)
  );

  // Clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External SIPO: 00 clear, 10 shift right with din entering the MSB
  always @(posedge clk) begin
    if (op == 2'b00) sipo <= 9'd0;
    else if (op == 2'b10) sipo <= {sdin, sipo[8:1]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expected {frame_err, parity_err, sipo}
  initial forever begin
    @(negedge clk);
    if (rst) begin
      in_frame  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (op == 2'b00) begin
        n_clear++;
        clear_cyc = cyc;
        last_evt  = cyc;
        in_frame  = 1'b1;
      end
      if (op == 2'b10) begin
        n_shift++;
        if (in_frame) check("shift_gap", cyc - last_evt, CPB);
        last_evt = cyc;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
        in_frame = 1'b0;
        check("done_width", prev_done, 0);
        if (exp_q.size() == 0) check("unexpected_done", 1, 0);
        else check("frame", {frame_err, parity_err, sipo}, exp_q.pop_front());
      end
      prev_done = done;
    end
  end

  // Driver tasks: all assume they are entered 1 time unit after a rising edge
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop);
    logic [9:0]  bits;
    logic [10:0] exp;
    int          nbits;
`ifdef RX_PARITY_EN
    exp   = {~stop, (^data) ^ par, par, data};
    bits  = {par, data, 1'b0};
    nbits = 10;
`else
    exp   = {~stop, 1'b0, data, 1'b0};
    bits  = {1'b0, data, 1'b0};
    nbits = 9;
`endif
    exp_q.push_back(exp);
    start_cyc = cyc;
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      idle(CPB);
    end
    rx = stop;
    idle(CPB);
  endtask

  task automatic check_frame();
    check("clear_count", n_clear, c0 + 1);
    check("shift_count", n_shift, s0 + NB);
    check("done_count", n_done, d0 + 1);
    check("clear_time", clear_cyc, start_cyc + 10);
    check("done_time", done_cyc, start_cyc + 11 + (NB + 1) * CPB);
  endtask

  task automatic snap();
    d0 = n_done;
    s0 = n_shift;
    c0 = n_clear;
  endtask

  initial begin
    logic [7:0] part;
    part = 8'h5A;

    idle(3);
    check("rst_op", op, 2'b01);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_perr", parity_err, 0);
    check("rst_state", state, 0);
    check("rst_sdin", sdin, 1);
    rst = 1'b0;
    idle(4);
    check("idle_op", op, 2'b01);

    // Plain frame with correct stop bit
    snap();
    send_frame(8'hA5, ^part ^ 1'b0, 1'b1);
    check_frame();
    check("a5_busy_after", busy, 0);
    idle(2 * CPB);

    // Five-cycle low glitch must be rejected at the mid-start sample
    snap();
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    check("glitch_busy", busy, 1);
    idle(30);
    check("glitch_busy_after", busy, 0);
    check("glitch_clear", n_clear, c0);
    check("glitch_done", n_done, d0);

    // Missing stop bit, then a break held for 40 bit times
    snap();
    send_frame(8'h3C, 1'b0, 1'b0);
    check_frame();
    idle(40 * CPB);
    check("break_done", n_done, d0 + 1);
    check("break_clear", n_clear, c0 + 1);
    check("break_busy", busy, 0);
    check("break_ferr_held", frame_err, 1);
    rx = 1'b1;
    idle(3 * CPB);
    check("break_release_clear", n_clear, c0 + 1);
    check("break_release_busy", busy, 0);
    check("break_release_ferr", frame_err, 1);

    // Reset in the middle of data bit 4
    snap();
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = part[i];
      idle(CPB);
    end
    rx = part[4];
    idle(CPB / 2);
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_op", op, 2'b01);
    idle(3);
    rst = 1'b0;
    idle(4);
    check("abort_no_done", n_done, d0);
    snap();
    send_frame(8'h5A, 1'b0, 1'b1);
    check_frame();
    idle(CPB);

    // Back-to-back frames with no idle gap
    snap();
    send_frame(8'h00, 1'b0, 1'b1);
    check_frame();
    snap();
    send_frame(8'hFF, 1'b0, 1'b1);
    check_frame();
    idle(CPB);

`ifdef RX_PARITY_EN
    snap();
    send_frame(8'h07, 1'b1, 1'b1);
    check_frame();
    check("par_ok", parity_err, 0);
    snap();
    send_frame(8'h07, 1'b0, 1'b1);
    check_frame();
    check("par_bad", parity_err, 1);
    idle(CPB);
`endif

    check("exp_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter ClksPerBit, default 434, clk_i cycles per bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk_i  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port rx_i  input  1  raw asynchronous serial line; idle high, 8N1 LSB-first (8E1 with RX_PARITY_EN).
REQ-005 SHALL have port op_o  output  2  SIPO command: 00 clear, 01 hold, 10 shift right (din into MSB).
REQ-006 SHALL have port sdin_o  output  1  sampled serial bit to the SIPO din.
REQ-007 SHALL have port done_o  output  1  one-cycle frame-complete pulse.
REQ-008 SHALL have port busy_o  output  1  high in any state except IDLE.
REQ-009 SHALL have port frame_err_o  output  1  stop bit sampled low.
REQ-010 SHALL have port parity_err_o  output  1  even-parity mismatch.

Function
REQ-011 SHALL pass rx_i through a 2-FF synchronizer; rx_s is the second stage, and all decisions use rx_s only.
REQ-012 SHALL drive sdin_o = rx_s combinationally.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, DONE, with a clk_cnt counter (0..ClksPerBit-1) and a bit_cnt counter; NBITS = 8, or 9 with RX_PARITY_EN.
REQ-014 SHALL drive op_o = 01 in every cycle except the clear and shift cycles defined below.
REQ-015 IDLE: SHALL keep an armed flag, set when rx_s = 1 and cleared on leaving IDLE; when armed and rx_s = 0 at cycle t0, SHALL enter START with clk_cnt = 0 at t0+1.
REQ-016 START: at clk_cnt = ClksPerBit/2-1 (cycle t0+ClksPerBit/2), if rx_s = 0, SHALL enter DATA with clk_cnt = 0, bit_cnt = 0, op_o = 00 that cycle, and clear frame_err_o/parity_err_o.
REQ-017 START: at the same point, if rx_s = 1 (glitch), SHALL return to IDLE with no clear, no shift and no done_o.
REQ-018 DATA: at each clk_cnt = ClksPerBit-1, SHALL assert op_o = 10 for one cycle, increment bit_cnt and wrap clk_cnt to 0, so shift k (1..NBITS) occurs at t0+ClksPerBit/2+k*ClksPerBit.
REQ-019 DATA: after shift NBITS, SHALL enter STOP.
REQ-020 STOP: at clk_cnt = ClksPerBit-1, SHALL sample rx_s, set frame_err_o = ~rx_s and enter DONE.
REQ-021 DONE: SHALL assert done_o for exactly one cycle, at t0+ClksPerBit/2+(NBITS+1)*ClksPerBit+1, then return to IDLE.
REQ-022 SHALL hold frame_err_o and parity_err_o stable from done_o until the next REQ-016 clear.
REQ-023 SHALL place the frame in the 9-bit SIPO as follows: without parity, data in SIPO[8:1]; with parity, data in SIPO[7:0] and parity in SIPO[8].
REQ-024 Break condition (line low through stop): SHALL raise frame_err_o and assert done_o, and SHALL NOT restart until rx_s returns high (REQ-015 armed flag).
REQ-025 A falling edge on rx_s during DATA or STOP SHALL NOT restart the frame.

Reset
REQ-026 While rst_i = 1: state = IDLE, counters = 0, armed = 0, synchronizer FFs = 1, op_o = 01, done_o = 0, busy_o = 0, frame_err_o = 0, parity_err_o = 0.
REQ-027 Reset asserted mid-frame SHALL abort immediately with no done_o; the SIPO holds partial contents until the next clear.

Configuration
REQ-028 Macro RX_PARITY_EN defined: NBITS = 9; the running XOR of the 9 shifted bits is computed, and at STOP sampling parity_err_o = XOR result (even parity expected).
REQ-029 Macro RX_PARITY_EN undefined: NBITS = 8; parity_err_o is tied to 0; no parity logic is present.

Verification (ClksPerBit = 16)
REQ-030 Reset, then send 0xA5 8N1 -> op_o=00 once, 8 shift pulses 16 cycles apart, done_o at t0+8+9*16+1=t0+153, SIPO[8:1]=0xA5, frame_err_o=0.
REQ-031 rx_i low pulse of 5 cycles in IDLE -> returns to IDLE, no op_o=00, no done_o, busy_o low again.
REQ-032 Send 0x3C with stop bit low, then line held low 40 bit times -> frame_err_o=1 with done_o, exactly one done_o, no new frame until line high.
REQ-033 With RX_PARITY_EN: 0x07 with parity 1 -> parity_err_o=0, SIPO[7:0]=0x07; 0x07 with parity 0 -> parity_err_o=1.
REQ-034 Assert rst_i during data bit 4 -> busy_o=0 at once, no done_o; next frame 0x5A received correctly.
REQ-035 Two back-to-back frames 0x00 and 0xFF, no idle gap -> two done_o pulses, correct data each, no errors.
